// File: rtl/hazard_controller_if.sv
// Hazard-controller bus: hazard information from the pipeline in, sequencing
// controls and statistics out. The pipeline side is the master.
interface hazard_controller_if #(
    parameter int REG_BITS = 4,
    parameter int CNT_BITS = 16
);
    logic [REG_BITS-1:0] ifid_rs;
    logic [REG_BITS-1:0] ifid_rt;
    logic [REG_BITS-1:0] idex_rd;
    logic                idex_mem_read;
    logic                branch_taken;
    logic                mem_req;
    logic                mem_ready;

    logic                pc_write;
    logic                ifid_write;
    logic                ifid_flush;
    logic                idex_bubble;
    logic                pipe_hold;
    logic                mem_error;
    logic [CNT_BITS-1:0] stall_cnt;
    logic [CNT_BITS-1:0] flush_cnt;

    modport master (
        output ifid_rs, ifid_rt, idex_rd, idex_mem_read, branch_taken, mem_req, mem_ready,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, mem_error,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  ifid_rs, ifid_rt, idex_rd, idex_mem_read, branch_taken, mem_req, mem_ready,
        output pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, mem_error,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller for the 5-stage core: load-use stalls, branch
// flushes, data-memory wait holds with a watchdog, and saturating statistics.
module hazard_controller #(
    parameter int REG_BITS    = 4,
    parameter int CNT_BITS    = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input logic            clk,
    input logic            rst,
    hazard_controller_if.slave hz
);
    localparam int WC_BITS = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t              state;
    logic [WC_BITS-1:0]  wait_cnt;
    logic [CNT_BITS-1:0] stall_cnt;
    logic [CNT_BITS-1:0] flush_cnt;
    logic                mem_error;

    logic load_use;
    logic hold_now;
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic pipe_hold;

    assign load_use = hz.idex_mem_read && (hz.idex_rd != '0) &&
                      ((hz.idex_rd == hz.ifid_rs) || (hz.idex_rd == hz.ifid_rt));

    // A memory access that is not ready freezes everything, masking branches and load-use.
    assign hold_now = ((state == RUN) && hz.mem_req && !hz.mem_ready) ||
                      ((state == MEM_WAIT) && !hz.mem_ready);

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;
        if (!rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (hold_now) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
        end else if (hz.branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            mem_error <= 1'b0;
        end else begin
            mem_error <= 1'b0;
            if (!pc_write && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_BITS'(1);
            end
            if (ifid_flush && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_BITS'(1);
            end
            case (state)
                RUN: begin
                    if (hz.mem_req && !hz.mem_ready) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WC_BITS'(1);
                    end
                end
                MEM_WAIT: begin
                    // Completion on the timeout cycle still wins over the abort.
                    if (hz.mem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WC_BITS'(MEM_TIMEOUT)) begin
                        state     <= RUN;
                        wait_cnt  <= '0;
                        mem_error <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WC_BITS'(1);
                    end
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    assign hz.pc_write    = pc_write;
    assign hz.ifid_write  = ifid_write;
    assign hz.ifid_flush  = ifid_flush;
    assign hz.idex_bubble = idex_bubble;
    assign hz.pipe_hold   = pipe_hold;
    assign hz.mem_error   = mem_error;
    assign hz.stall_cnt   = stall_cnt;
    assign hz.flush_cnt   = flush_cnt;
endmodule

// File: tb/tb_hazard_controller.sv
// Table-driven bench for hazard_controller: each row is one clock of stimulus with
// the expected same-cycle controls and the registered mem_error that follows it.
module tb_hazard_controller;
    localparam int RB      = 4;
    localparam int CB      = 4;
    localparam int TIMEOUT = 15;
    localparam int CMAX    = (1 << CB) - 1;

    // Control vector order: {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold}
    localparam logic [4:0] RUNV  = 5'b11000;
    localparam logic [4:0] RSTV  = 5'b00110;
    localparam logic [4:0] HOLD  = 5'b00001;
    localparam logic [4:0] LUV   = 5'b00010;
    localparam logic [4:0] FLSH  = 5'b10110;
    localparam logic [4:0] ALL   = 5'b11111;
    localparam logic [4:0] FCARE = 5'b10111;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    hazard_controller_if #(.REG_BITS(RB), .CNT_BITS(CB)) hz ();

    hazard_controller #(
        .REG_BITS(RB),
        .CNT_BITS(CB),
        .MEM_TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz(hz.slave)
    );

    typedef struct {
        logic [8*12-1:0] name;
        logic            rstn;
        logic [RB-1:0]   rs;
        logic [RB-1:0]   rt;
        logic [RB-1:0]   rd;
        logic            mr;
        logic            br;
        logic            mreq;
        logic            mrdy;
        logic [4:0]      exp;
        logic [4:0]      care;
        logic            err;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   checks    = 0;
    int   errors    = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;

    task automatic addVec(input logic [8*12-1:0] n, input logic rstn,
                          input int rs, input int rt, input int rd,
                          input logic mr, input logic br, input logic mreq, input logic mrdy,
                          input logic [4:0] exp, input logic [4:0] care, input logic err);
        vec_t v;
        v.name = n;
        v.rstn = rstn;
        v.rs   = RB'(rs);
        v.rt   = RB'(rt);
        v.rd   = RB'(rd);
        v.mr   = mr;
        v.br   = br;
        v.mreq = mreq;
        v.mrdy = mrdy;
        v.exp  = exp;
        v.care = care;
        v.err  = err;
        tbl.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        rst              = v.rstn;
        hz.ifid_rs       = v.rs;
        hz.ifid_rt       = v.rt;
        hz.idex_rd       = v.rd;
        hz.idex_mem_read = v.mr;
        hz.branch_taken  = v.br;
        hz.mem_req       = v.mreq;
        hz.mem_ready     = v.mrdy;
        sb.push_back(v);
    endtask

    task automatic checkOutput();
        vec_t       v;
        logic [4:0] act;
        @(negedge clk);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard actual=empty required=entry");
            return;
        end
        v   = sb.pop_front();
        act = {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_bubble, hz.pipe_hold};
        checks++;
        if ((act & v.care) !== (v.exp & v.care)) begin
            errors++;
            $display("[TB] FAIL %0s ctrl actual=%b required=%b care=%b", v.name, act, v.exp, v.care);
        end
        @(posedge clk);
        #1;
        if (!v.rstn) begin
            exp_stall = 0;
            exp_flush = 0;
        end else begin
            if (!v.exp[4] && exp_stall < CMAX) exp_stall++;
            if (v.exp[2] && exp_flush < CMAX) exp_flush++;
        end
        checks++;
        if (hz.mem_error !== v.err) begin
            errors++;
            $display("[TB] FAIL %0s mem_error actual=%b required=%b", v.name, hz.mem_error, v.err);
        end
        checks++;
        if (hz.stall_cnt !== CB'(exp_stall)) begin
            errors++;
            $display("[TB] FAIL %0s stall_cnt actual=%0d required=%0d", v.name, hz.stall_cnt, exp_stall);
        end
        checks++;
        if (hz.flush_cnt !== CB'(exp_flush)) begin
            errors++;
            $display("[TB] FAIL %0s flush_cnt actual=%0d required=%0d", v.name, hz.flush_cnt, exp_flush);
        end
    endtask

    initial begin
        hz.ifid_rs       = '0;
        hz.ifid_rt       = '0;
        hz.idex_rd       = '0;
        hz.idex_mem_read = 1'b0;
        hz.branch_taken  = 1'b0;
        hz.mem_req       = 1'b0;
        hz.mem_ready     = 1'b0;

        addVec("reset",    0, 0, 0, 0, 0, 0, 0, 0, RSTV, ALL, 0);
        addVec("reset",    0, 0, 0, 0, 0, 0, 0, 0, RSTV, ALL, 0);
        addVec("idle",     1, 0, 0, 0, 0, 0, 0, 0, RUNV, ALL, 0);
        addVec("lu_rt",    1, 5, 3, 3, 1, 0, 0, 0, LUV,  ALL, 0);
        addVec("lu_nop",   1, 5, 3, 0, 0, 0, 0, 0, RUNV, ALL, 0);
        addVec("rd_zero",  1, 0, 0, 0, 1, 0, 0, 0, RUNV, ALL, 0);
        addVec("lu_rs",    1, 7, 2, 7, 1, 0, 0, 0, LUV,  ALL, 0);
        addVec("no_load",  1, 7, 2, 7, 0, 0, 0, 0, RUNV, ALL, 0);
        addVec("br_lu",    1, 1, 4, 1, 1, 1, 0, 0, FLSH, FCARE, 0);
        addVec("idle",     1, 0, 0, 0, 0, 0, 0, 0, RUNV, ALL, 0);

        addVec("mwait",    1, 0, 0, 0, 0, 0, 1, 0, HOLD, ALL, 0);
        addVec("mwait_br", 1, 0, 0, 0, 0, 1, 1, 0, HOLD, ALL, 0);
        addVec("mwait_lu", 1, 0, 3, 3, 1, 0, 1, 0, HOLD, ALL, 0);
        addVec("mdone",    1, 0, 0, 0, 0, 0, 1, 1, RUNV, ALL, 0);
        addVec("mwait",    1, 0, 0, 0, 0, 0, 1, 0, HOLD, ALL, 0);
        addVec("mdone_br", 1, 0, 0, 0, 0, 1, 1, 1, FLSH, FCARE, 0);
        addVec("mwait",    1, 0, 0, 0, 0, 0, 1, 0, HOLD, ALL, 0);
        addVec("mdone_lu", 1, 2, 0, 2, 1, 0, 1, 1, LUV,  ALL, 0);
        addVec("idle",     1, 0, 0, 0, 0, 0, 0, 0, RUNV, ALL, 0);

        // Ready arriving on the timeout cycle completes the access without an error.
        for (int i = 0; i < 15; i++) addVec("to_ready_w", 1, 0, 0, 0, 0, 0, 1, 0, HOLD, ALL, 0);
        addVec("to_ready",   1, 0, 0, 0, 0, 0, 1, 1, RUNV, ALL, 0);
        addVec("idle",       1, 0, 0, 0, 0, 0, 0, 0, RUNV, ALL, 0);

        // One RUN hold cycle plus MEM_WAIT with wait_cnt 1..15; the abort follows the last.
        for (int i = 0; i < 15; i++) addVec("timeout_w", 1, 0, 0, 0, 0, 1, 1, 0, HOLD, ALL, 0);
        addVec("timeout",    1, 0, 0, 0, 0, 0, 1, 0, HOLD, ALL, 1);
        addVec("after_to",   1, 0, 0, 0, 0, 0, 0, 0, RUNV, ALL, 0);
        addVec("after_to",   1, 0, 0, 0, 0, 0, 0, 0, RUNV, ALL, 0);

        for (int i = 0; i < 5; i++) addVec("rstmid_w", 1, 0, 0, 0, 0, 0, 1, 0, HOLD, ALL, 0);
        addVec("rst_mid",    0, 0, 0, 0, 0, 0, 1, 0, RSTV, ALL, 0);
        for (int i = 0; i < 18; i++) addVec("rstmid_idle", 1, 0, 0, 0, 0, 0, 0, 0, RUNV, ALL, 0);

        for (int i = 0; i < 17; i++) addVec("flush_sat", 1, 0, 0, 0, 0, 1, 0, 0, FLSH, FCARE, 0);
        addVec("idle",       1, 0, 0, 0, 0, 0, 0, 0, RUNV, ALL, 0);

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
            checkOutput();
        end

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_left actual=%0d required=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
